// File: rtl/id_stage_if.sv
// id_stage_if: decode-stage handshake, forwarding and branch bundle
interface id_stage_if;
  logic         es_allowin;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_to_es_valid;
  logic [150:0] ds_to_es_bus;
  logic [32:0]  br_bus;
  logic [39:0]  es_fwd_bus;
  logic [38:0]  ms_fwd_bus;
  logic [37:0]  ws_to_rf_bus;
  modport master (
    output es_allowin, fs_to_ds_valid, fs_to_ds_bus, es_fwd_bus, ms_fwd_bus, ws_to_rf_bus,
    input  ds_allowin, ds_to_es_valid, ds_to_es_bus, br_bus
  );
  modport slave (
    input  es_allowin, fs_to_ds_valid, fs_to_ds_bus, es_fwd_bus, ms_fwd_bus, ws_to_rf_bus,
    output ds_allowin, ds_to_es_valid, ds_to_es_bus, br_bus
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: decode, regfile read with forwarding, load-use interlock and branch resolution
module id_stage (
  input logic       clk,
  input logic       reset,
  id_stage_if.slave bus
);
  logic        ds_valid_q, ds_valid_d;
  logic [31:0] inst_q, inst_d, pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic        es_valid, es_gr_we, es_load, ms_valid, ms_gr_we, rf_we;
  logic [4:0]  es_dest, ms_dest, rf_waddr;
  logic [31:0] es_result, ms_result, rf_wdata;
  logic [4:0]  rd, rj, rk, src2, dest;
  logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor, op_or, op_xor;
  logic        op_slli, op_srli, op_srai, op_lu12i, op_addi, op_ld, op_st;
  logic        op_jirl, op_b, op_bl, op_beq, op_bne;
  logic        is_3r, is_shift, src2_rd, rj_used, src2_used, gr_we, link;
  logic        load_use, ready_go, taken;
  logic [11:0] alu_op;
  logic [31:0] imm, rj_value, rkd_value, target;
  assign {es_valid, es_gr_we, es_load, es_dest, es_result} = bus.es_fwd_bus;
  assign {ms_valid, ms_gr_we, ms_dest, ms_result} = bus.ms_fwd_bus;
  assign {rf_we, rf_waddr, rf_wdata} = bus.ws_to_rf_bus;
  assign rd = inst_q[4:0];
  assign rj = inst_q[9:5];
  assign rk = inst_q[14:10];
  assign op_add   = inst_q[31:15] == 17'h00020;
  assign op_sub   = inst_q[31:15] == 17'h00022;
  assign op_slt   = inst_q[31:15] == 17'h00024;
  assign op_sltu  = inst_q[31:15] == 17'h00025;
  assign op_nor   = inst_q[31:15] == 17'h00028;
  assign op_and   = inst_q[31:15] == 17'h00029;
  assign op_or    = inst_q[31:15] == 17'h0002a;
  assign op_xor   = inst_q[31:15] == 17'h0002b;
  assign op_slli  = inst_q[31:15] == 17'h00081;
  assign op_srli  = inst_q[31:15] == 17'h00089;
  assign op_srai  = inst_q[31:15] == 17'h00091;
  assign op_addi  = inst_q[31:22] == 10'h00a;
  assign op_ld    = inst_q[31:22] == 10'h0a2;
  assign op_st    = inst_q[31:22] == 10'h0a6;
  assign op_lu12i = inst_q[31:25] == 7'h0a;
  assign op_jirl  = inst_q[31:26] == 6'h13;
  assign op_b     = inst_q[31:26] == 6'h14;
  assign op_bl    = inst_q[31:26] == 6'h15;
  assign op_beq   = inst_q[31:26] == 6'h16;
  assign op_bne   = inst_q[31:26] == 6'h17;
  assign is_3r     = op_add | op_sub | op_slt | op_sltu | op_and | op_nor | op_or | op_xor;
  assign is_shift  = op_slli | op_srli | op_srai;
  assign src2_rd   = op_beq | op_bne | op_st;
  assign rj_used   = is_3r | is_shift | op_addi | op_ld | op_st | op_jirl | op_beq | op_bne;
  assign src2_used = is_3r | src2_rd;
  assign src2      = src2_rd ? rd : rk;
  assign dest      = op_bl ? 5'd1 : rd;
  assign link      = op_jirl | op_bl;
  assign gr_we     = (is_3r | is_shift | op_addi | op_lu12i | op_ld | link) && dest != 5'd0;
  assign alu_op = {op_add | op_addi | op_ld | op_st | link, op_sub, op_slt, op_sltu, op_and, op_nor,
                   op_or, op_xor, op_slli, op_srli, op_srai, op_lu12i};
  assign imm = (op_addi | op_ld | op_st)    ? {{20{inst_q[21]}}, inst_q[21:10]} :
               is_shift                     ? {27'd0, inst_q[14:10]} :
               op_lu12i                     ? {inst_q[24:5], 12'd0} :
               (op_beq | op_bne | op_jirl)  ? {{14{inst_q[25]}}, inst_q[25:10], 2'b00} :
               (op_b | op_bl)               ? {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b00} : '0;
  // A matching load in EX is not a usable source; it falls through and the interlock covers used operands
  function automatic logic [31:0] fwd(input logic [4:0] a);
    return a == 5'd0 ? '0 :
           (es_valid && es_gr_we && !es_load && es_dest == a) ? es_result :
           (ms_valid && ms_gr_we && ms_dest == a) ? ms_result :
           (rf_we && rf_waddr == a) ? rf_wdata : rf_q[a];
  endfunction
  always_comb begin
    rj_value  = fwd(rj);
    rkd_value = fwd(src2);
  end
  assign load_use = ds_valid_q && es_valid && es_gr_we && es_load && es_dest != 5'd0 &&
                    ((rj_used && es_dest == rj) || (src2_used && es_dest == src2));
  assign ready_go = !load_use;
  assign taken    = op_b | op_bl | op_jirl | (op_beq && rj_value == rkd_value) | (op_bne && rj_value != rkd_value);
  assign target   = (op_jirl ? rj_value : pc_q) + imm;
  assign bus.br_bus         = {ds_valid_q && ready_go && taken, target};
  assign bus.ds_allowin     = !ds_valid_q || (ready_go && bus.es_allowin);
  assign bus.ds_to_es_valid = ds_valid_q && ready_go;
  assign bus.ds_to_es_bus   = {alu_op, op_ld, link, is_shift | op_lu12i | op_addi | op_ld | op_st, link,
                               gr_we, op_st, dest, imm, rj_value, rkd_value, pc_q};
  always_comb begin
    ds_valid_d     = bus.ds_allowin ? bus.fs_to_ds_valid : ds_valid_q;
    {inst_d, pc_d} = (bus.ds_allowin && bus.fs_to_ds_valid) ? bus.fs_to_ds_bus : {inst_q, pc_q};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized decode-stage bench against a table-driven reference model
module tb_id_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  id_stage_if ifc();
  id_stage dut (.clk(clk), .reset(reset), .bus(ifc));

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] rf_m [32];
  logic        m_valid = 1'b0;
  logic [31:0] m_inst = '0, m_pc = '0;

  typedef struct packed {
    logic         stall;
    logic         taken;
    logic [31:0]  target;
    logic [150:0] bus;
  } exp_t;

  // index order: add sub slt sltu and nor or xor slli srli srai lu12i addi ld st jirl b bl beq bne
  localparam logic [31:0] MATCH [20] = '{
    32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000, 32'h00148000,
    32'h00140000, 32'h00150000, 32'h00158000, 32'h00408000, 32'h00448000,
    32'h00488000, 32'h14000000, 32'h02800000, 32'h28800000, 32'h29800000,
    32'h4C000000, 32'h50000000, 32'h54000000, 32'h58000000, 32'h5C000000};

  function automatic logic [31:0] mask_of(input int k);
    return k <= 10 ? 32'hFFFF8000 : k == 11 ? 32'hFE000000 : k <= 14 ? 32'hFFC00000 : 32'hFC000000;
  endfunction

  function automatic int classify(input logic [31:0] i);
    for (int k = 0; k < 20; k++)
      if ((i & mask_of(k)) == MATCH[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] a);
    if (a == 0) return 0;
    if (ifc.es_fwd_bus[39] && ifc.es_fwd_bus[38] && !ifc.es_fwd_bus[37] && ifc.es_fwd_bus[36:32] == a)
      return ifc.es_fwd_bus[31:0];
    if (ifc.ms_fwd_bus[38] && ifc.ms_fwd_bus[37] && ifc.ms_fwd_bus[36:32] == a) return ifc.ms_fwd_bus[31:0];
    if (ifc.ws_to_rf_bus[37] && ifc.ws_to_rf_bus[36:32] == a) return ifc.ws_to_rf_bus[31:0];
    return rf_m[a];
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    int k, v;
    logic [4:0] rd, rj, second, dest;
    logic [31:0] imm, rjv, r2v;
    logic [11:0] alu;
    logic use_rj, use2, we;
    k = classify(inst);
    rd = inst[4:0];
    rj = inst[9:5];
    second = (k == 14 || k == 18 || k == 19) ? rd : inst[14:10];
    use_rj = k >= 0 && k != 11 && k != 16 && k != 17;
    use2 = (k >= 0 && k <= 7) || k == 14 || k == 18 || k == 19;
    dest = k == 17 ? 5'd1 : rd;
    we = k >= 0 && k != 14 && k != 16 && k != 18 && k != 19 && dest != 0;
    imm = 0;
    if (k >= 8 && k <= 10) imm = 32'(inst[14:10]);
    else if (k == 11) imm = 32'(inst[24:5]) * 4096;
    else if (k >= 12 && k <= 14) begin
      v = int'(inst[21:10]); if (v > 2047) v -= 4096; imm = 32'(v);
    end else if (k == 15 || k == 18 || k == 19) begin
      v = int'(inst[25:10]); if (v > 32767) v -= 65536; imm = 32'(v * 4);
    end else if (k == 16 || k == 17) begin
      v = int'({inst[9:0], inst[25:10]}); if (v >= (1 << 25)) v -= (1 << 26); imm = 32'(v * 4);
    end
    alu = 0;
    if (k >= 0 && k <= 11) alu = 12'(1 << (11 - k));
    else if (k == 12 || k == 13 || k == 14 || k == 15 || k == 17) alu = 12'h800;
    rjv = src_val(rj);
    r2v = src_val(second);
    e.stall = ifc.es_fwd_bus[39] && ifc.es_fwd_bus[38] && ifc.es_fwd_bus[37] && ifc.es_fwd_bus[36:32] != 0 &&
              ((use_rj && ifc.es_fwd_bus[36:32] == rj) || (use2 && ifc.es_fwd_bus[36:32] == second));
    e.taken = k == 15 || k == 16 || k == 17 || (k == 18 && rjv == r2v) || (k == 19 && rjv != r2v);
    e.target = (k == 15 ? rjv : pc) + imm;
    e.bus = {alu, k == 13, k == 15 || k == 17, k >= 8 && k <= 14, k == 15 || k == 17, we, k == 14,
             dest, imm, rjv, r2v, pc};
    return e;
  endfunction

  task automatic chk(input string name, input logic [150:0] got, input logic [150:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  exp_t ue;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_inst <= '0;
      m_pc <= '0;
    end else begin
      ue = model(m_inst, m_pc);
      if (!m_valid || (!ue.stall && ifc.es_allowin)) begin
        m_valid <= ifc.fs_to_ds_valid;
        if (ifc.fs_to_ds_valid) {m_inst, m_pc} <= ifc.fs_to_ds_bus;
      end
    end
  end

  always @(posedge clk)
    if (ifc.ws_to_rf_bus[37] && ifc.ws_to_rf_bus[36:32] != 0) rf_m[ifc.ws_to_rf_bus[36:32]] <= ifc.ws_to_rf_bus[31:0];

  exp_t ce;
  logic go;
  always @(negedge clk) begin
    ce = model(m_inst, m_pc);
    go = m_valid && !ce.stall;
    chk("ds_allowin", 151'(ifc.ds_allowin), 151'(!m_valid || (go && ifc.es_allowin)));
    chk("ds_to_es_valid", 151'(ifc.ds_to_es_valid), 151'(go));
    chk("br_taken", 151'(ifc.br_bus[32]), 151'(go && ce.taken));
    if (go) chk("ds_to_es_bus", ifc.ds_to_es_bus, ce.bus);
    if (go && ce.taken) chk("br_target", 151'(ifc.br_bus[31:0]), 151'(ce.target));
  end

  task automatic drive(input logic fv, input logic [31:0] inst, input logic [31:0] pc, input logic ea,
                       input logic [39:0] es, input logic [38:0] ms, input logic [37:0] ws);
    @(posedge clk); #2;
    ifc.fs_to_ds_valid = fv;
    ifc.fs_to_ds_bus = {inst, pc};
    ifc.es_allowin = ea;
    ifc.es_fwd_bus = es;
    ifc.ms_fwd_bus = ms;
    ifc.ws_to_rf_bus = ws;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b1, '0, '0, '0);
  endtask

  function automatic logic [31:0] rand_inst();
    int k;
    logic [31:0] i;
    k = $urandom_range(0, 20);
    i = (k == 20) ? $urandom : (MATCH[k] | ($urandom & ~mask_of(k)));
    i[4:0] = 5'($urandom_range(0, 7));
    i[9:5] = 5'($urandom_range(0, 7));
    i[14:10] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin
    ifc.fs_to_ds_valid = 0; ifc.fs_to_ds_bus = '0; ifc.es_allowin = 1;
    ifc.es_fwd_bus = '0; ifc.ms_fwd_bus = '0; ifc.ws_to_rf_bus = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 151'(ifc.ds_to_es_valid), 151'(0));
    chk("reset_allowin", 151'(ifc.ds_allowin), 151'(1));
    @(posedge clk); #2 reset = 0;
    for (int i = 1; i < 32; i++) drive(0, '0, '0, 1, '0, '0, {1'b1, 5'(i), 32'(i) * 32'h01010101 + 32'd7});
    drive(0, '0, '0, 1, '0, '0, {1'b1, 5'd1, 32'd5});
    drive(0, '0, '0, 1, '0, '0, {1'b1, 5'd3, 32'd0});
    drive(0, '0, '0, 1, '0, '0, {1'b1, 5'd7, 32'd9});
    drive(0, '0, '0, 1, '0, '0, {1'b1, 5'd8, 32'd9});
    // addi.w r2,r1,3
    drive(1, 32'h02800C22, 32'h1c000000, 1, '0, '0, '0);
    idle();
    @(negedge clk);
    chk("t1_valid", 151'(ifc.ds_to_es_valid), 151'(1));
    chk("t1_rj", 151'(ifc.ds_to_es_bus[95:64]), 151'(5));
    chk("t1_imm", 151'(ifc.ds_to_es_bus[127:96]), 151'(3));
    chk("t1_dest", 151'(ifc.ds_to_es_bus[132:128]), 151'(2));
    chk("t1_gr_we", 151'(ifc.ds_to_es_bus[134]), 151'(1));
    chk("t1_pc", 151'(ifc.ds_to_es_bus[31:0]), 151'(32'h1c000000));
    // add.w r4,r3,r3 with r3 forwarded from EX
    drive(1, 32'h00100C64, 32'h1c000004, 1, '0, '0, '0);
    drive(0, '0, '0, 1, {1'b1, 1'b1, 1'b0, 5'd3, 32'h1234}, '0, '0);
    @(negedge clk);
    chk("t2_rj", 151'(ifc.ds_to_es_bus[95:64]), 151'(32'h1234));
    chk("t2_rkd", 151'(ifc.ds_to_es_bus[63:32]), 151'(32'h1234));
    chk("t2_valid", 151'(ifc.ds_to_es_valid), 151'(1));
    // sub.w r6,r5,r0 behind a load of r5
    drive(1, 32'h001100A6, 32'h1c000008, 1, '0, '0, '0);
    drive(0, '0, '0, 1, {1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD}, '0, '0);
    @(negedge clk);
    chk("t3_allowin", 151'(ifc.ds_allowin), 151'(0));
    chk("t3_stall_valid", 151'(ifc.ds_to_es_valid), 151'(0));
    drive(0, '0, '0, 1, '0, {1'b1, 1'b1, 5'd5, 32'hAA}, '0);
    @(negedge clk);
    chk("t3_rj", 151'(ifc.ds_to_es_bus[95:64]), 151'(32'hAA));
    chk("t3_valid", 151'(ifc.ds_to_es_valid), 151'(1));
    // beq / bne r7,r8 (both 9), offs16=4
    drive(1, 32'h580010E8, 32'h1c000010, 1, '0, '0, '0);
    idle();
    @(negedge clk);
    chk("t4_beq", 151'(ifc.br_bus), 151'({1'b1, 32'h1c000020}));
    drive(1, 32'h5C0010E8, 32'h1c000010, 1, '0, '0, '0);
    idle();
    @(negedge clk);
    chk("t4_bne", 151'(ifc.br_bus[32]), 151'(0));
    // or r9,r1,r7 held by back-pressure
    drive(1, 32'h00151C29, 32'h1c000020, 1, '0, '0, '0);
    for (int j = 0; j < 3; j++) begin
      drive(1, $urandom, 32'h1c000100 + 32'(j * 4), 0, '0, '0, '0);
      @(negedge clk);
      chk("t5_allowin", 151'(ifc.ds_allowin), 151'(0));
      chk("t5_pc", 151'(ifc.ds_to_es_bus[31:0]), 151'(32'h1c000020));
      chk("t5_ops", 151'(ifc.ds_to_es_bus[95:32]), 151'({32'd5, 32'd9}));
    end
    idle();
    @(negedge clk);
    chk("t5_issue", 151'(ifc.ds_to_es_valid), 151'(1));
    idle();
    @(negedge clk);
    chk("t5_once", 151'(ifc.ds_to_es_valid), 151'(0));
    // jirl r1,r2,8 then asynchronous reset
    drive(1, 32'h4C000841, 32'h1c000030, 1, '0, '0, '0);
    drive(0, '0, '0, 0, '0, '0, '0);
    @(negedge clk);
    chk("t6_jirl", 151'(ifc.br_bus), 151'({1'b1, 32'h02020211}));
    #3 reset = 1;
    #1;
    chk("t6_rst_valid", 151'(ifc.ds_to_es_valid), 151'(0));
    chk("t6_rst_taken", 151'(ifc.br_bus[32]), 151'(0));
    @(posedge clk); #2 ifc.ws_to_rf_bus = {1'b1, 5'd0, 32'hFFFFFFFF};
    @(posedge clk); #2 ifc.ws_to_rf_bus = '0; reset = 0;
    drive(1, 32'h0010000A, 32'h1c000040, 1, '0, '0, '0);
    idle();
    @(negedge clk);
    chk("t6_first", 151'(ifc.ds_to_es_valid), 151'(1));
    chk("t6_r0", 151'(ifc.ds_to_es_bus[95:32]), 151'(0));
    repeat (3000)
      drive($urandom_range(0, 3) != 0, rand_inst(), {$urandom_range(0, 65535), 2'b00} + 32'h1c000000,
            $urandom_range(0, 3) != 0,
            {1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 32'($urandom)},
            {1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)},
            {1'($urandom), 5'($urandom_range(0, 9)), 32'($urandom)});
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
